// File: rtl/ifmap_stream_writer_if.sv
// Handshake bundle between the IFMap stream writer, its upstream activation
// source and the IFMap circular buffer it fills.
interface ifmap_stream_writer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;
    logic                  buf_ready;
    logic [DATA_WIDTH+1:0] din;
    logic                  write_en;

    // Writer side: consumes the upstream stream, drives the buffer write port.
    modport master (
        input  data_in, data_valid, buf_ready,
        output data_ready, din, write_en
    );

    // Environment side: upstream source plus buffer.
    modport slave (
        output data_in, data_valid, buf_ready,
        input  data_ready, din, write_en
    );
endinterface

// File: rtl/ifmap_stream_writer.sv
// IFMap stream writer: tags upstream activations with start-of-row (SOR) and
// end-of-stream (EOS) flags and pushes them into the IFMap circular buffer
// through a single-entry hold register, one word per cycle when unstalled.
module ifmap_stream_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    input  logic [LEN_WIDTH-1:0] row_len,
    input  logic [LEN_WIDTH-1:0] row_cnt,
    ifmap_stream_writer_if.master bus,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [LEN_WIDTH-1:0]  word_idx;
    logic [LEN_WIDTH-1:0]  row_idx;
    logic                  hold_valid;
    logic [DATA_WIDTH+1:0] hold_word;
    logic                  eos_taken;   // EOS word already accepted; stop pulling upstream

    logic in_stream;
    logic accept;
    logic last_word;
    logic last_row;

    assign in_stream = (state == STREAM);
    assign last_word = (word_idx == len_q - LEN_WIDTH'(1));
    assign last_row  = (row_idx == cnt_q - LEN_WIDTH'(1));

    // Hold register drains straight into the buffer; a new word may enter in
    // the same cycle the old one leaves, giving zero-bubble throughput.
    assign bus.write_en   = in_stream & hold_valid & bus.buf_ready;
    assign bus.data_ready = in_stream & ~eos_taken & (~hold_valid | bus.buf_ready);
    assign bus.din        = hold_word;
    assign accept         = bus.data_valid & bus.data_ready;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Transfer FSM with framing counters and hold register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            word_idx   <= '0;
            row_idx    <= '0;
            hold_valid <= 1'b0;
            hold_word  <= '0;
            eos_taken  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        len_q      <= row_len;
                        cnt_q      <= row_cnt;
                        word_idx   <= '0;
                        row_idx    <= '0;
                        hold_valid <= 1'b0;
                        eos_taken  <= 1'b0;
                        // Empty transfer: nothing to write, just signal completion.
                        state <= (row_len == '0 || row_cnt == '0) ? DONE : STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        hold_valid <= 1'b1;
                        hold_word  <= {(word_idx == '0), (last_word & last_row), bus.data_in};
                        if (last_word) begin
                            word_idx  <= '0;
                            row_idx   <= row_idx + LEN_WIDTH'(1);
                            eos_taken <= last_row;
                        end else begin
                            word_idx <= word_idx + LEN_WIDTH'(1);
                        end
                    end else if (bus.write_en) begin
                        hold_valid <= 1'b0;
                    end
                    // No accept can coincide with the EOS write (eos_taken blocks it).
                    if (bus.write_en && hold_word[DATA_WIDTH]) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifmap_stream_writer.sv
// Scoreboard bench for ifmap_stream_writer: the upstream driver pushes the
// expected tagged word whenever a word is accepted; the buffer-side monitor
// pops and compares on every write strobe.
module tb_ifmap_stream_writer;
    localparam int DW = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          Start = 1'b0;
    logic [LW-1:0] row_len = '0;
    logic [LW-1:0] row_cnt = '0;
    logic          busy, done;

    ifmap_stream_writer_if #(.DATA_WIDTH(DW)) bus ();

    ifmap_stream_writer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk     (clk),
        .rst     (rst),
        .Start   (Start),
        .row_len (row_len),
        .row_cnt (row_cnt),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] src_q[$];
    int wr_cyc[$];
    int eos_cyc = -100;
    int done_cnt = 0;
    int done_cyc = -100;
    logic [DW+1:0] last_din = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Buffer-side monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.write_en) begin
                if (exp_q.size() == 0) chk("unexpected_write", 32'(bus.din), 32'hdead);
                else chk("din", 32'(bus.din), 32'(exp_q.pop_front()));
                wr_cyc.push_back(cyc);
                last_din = bus.din;
                if (bus.din[DW]) eos_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic pulse_start(input int len, input int cnt);
        row_len = LW'(len);
        row_cnt = LW'(cnt);
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    // Stream len*cnt words; buf_ready low for stall_len cycles from stall_start.
    // abort_after >= 0 returns right after that many words were accepted.
    task automatic xfer(input int len, input int cnt, input int stall_start,
                        input int stall_len, input int abort_after);
        int total, i, c, wr0, dc0;
        logic [DW-1:0] d;
        logic [DW+1:0] prev_din;
        logic stalled;
        total = len * cnt;
        i = 0;
        c = 0;
        wr0 = wr_cyc.size();
        dc0 = done_cnt;
        prev_din = '0;
        pulse_start(len, cnt);
        while (i < total && c < 500 && !(abort_after >= 0 && i == abort_after)) begin
            stalled = (c >= stall_start && c < stall_start + stall_len);
            bus.buf_ready = ~stalled;
            d = (src_q.size() != 0) ? src_q[0] : DW'($urandom_range(0, 65535));
            bus.data_valid = 1'b1;
            bus.data_in = d;
            @(negedge clk);
            if (stalled) begin
                chk("stall_we", 32'(bus.write_en), 0);
                chk("stall_ready", 32'(bus.data_ready), 0);
                if (c > stall_start) chk("stall_din", 32'(bus.din), 32'(prev_din));
            end
            prev_din = bus.din;
            if (bus.data_ready) begin
                exp_q.push_back({(i % len) == 0, i == total - 1, d});
                if (src_q.size() != 0) void'(src_q.pop_front());
                i++;
            end
            @(posedge clk); #1;
            c++;
        end
        if (c >= 500) chk("accept_timeout", c, 0);
        bus.data_valid = 1'b0;
        bus.buf_ready = 1'b1;
        if (abort_after >= 0) return;
        // Upstream keeps offering data; writer must refuse after EOS.
        bus.data_valid = 1'b1;
        @(negedge clk);
        chk("ready_after_eos", 32'(bus.data_ready), 0);
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        c = 0;
        while (done_cnt == dc0 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("done_seen", 32'(done_cnt - dc0), 1);
        chk("done_lat", 32'(done_cyc), 32'(eos_cyc + 1));
        chk("nwrites", 32'(wr_cyc.size() - wr0), 32'(total));
        chk("q_empty", 32'(exp_q.size()), 0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        int w0, dc0;
        bus.data_valid = 1'b0;
        bus.data_in = '0;
        bus.buf_ready = 1'b1;
        #12;
        chk("rst_ready", 32'(bus.data_ready), 0);
        chk("rst_we", 32'(bus.write_en), 0);
        chk("rst_din", 32'(bus.din), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Two-word row with known data, always ready.
        src_q.push_back(16'hFFDF);
        src_q.push_back(16'h0020);
        w0 = wr_cyc.size();
        xfer(2, 1, 1000, 0, -1);
        chk("t1_consecutive", 32'(wr_cyc[w0+1] - wr_cyc[w0]), 1);
        chk("t1_last_din", 32'(last_din), 32'h10020);

        xfer(7, 1, 1000, 0, -1);       // single long row
        xfer(3, 2, 1000, 0, -1);       // two rows
        xfer(6, 1, 2, 5, -1);          // 5-cycle buffer stall mid-row
        xfer(15, 15, 40, 3, -1);       // maximum framing with a stall

        // Empty transfer, plus a Start while busy that must be ignored.
        w0 = wr_cyc.size();
        dc0 = done_cnt;
        row_len = '0;
        row_cnt = 4'd3;
        Start = 1'b1;
        @(posedge clk); #1;
        row_len = 4'd2;                // Start still high while in DONE
        @(negedge clk);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 1);
        @(posedge clk); #1;
        Start = 1'b0;
        @(negedge clk);
        chk("zero_done_once", 32'(done), 0);
        chk("zero_ignored", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_nowrites", 32'(wr_cyc.size() - w0), 0);
        chk("zero_done_cnt", 32'(done_cnt - dc0), 1);

        // Reset mid-transfer after two of four words.
        xfer(4, 1, 1000, 0, 2);
        rst = 1'b0;
        #1;
        chk("mid_rst_we", 32'(bus.write_en), 0);
        chk("mid_rst_din", 32'(bus.din), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(bus.data_ready), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1, 1000, 0, -1);
        chk("one_tag", 32'(last_din[DW+1:DW]), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ifmap_stream_writer.md
Name: ifmap_stream_writer

Overview:
Producer side of the IFMap buffer interface. Accepts raw 16-bit activations from an upstream valid/ready source and tags each word with row-framing flags. Pushes the resulting 18-bit words into the IFMap circular_buffer (PAR_WRITE=1) that the Processing_element drains. Framing is set by a per-transfer row length and row count, latched on Start.

Parameters:
DATA_WIDTH, 16, activation width; buffer word width is DATA_WIDTH+2
LEN_WIDTH, 4, width of row_len and row_cnt config inputs

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
Start  input  1  one-cycle pulse; latches config and begins a transfer
row_len  input  LEN_WIDTH  words per row (sampled on Start)
row_cnt  input  LEN_WIDTH  rows per transfer (sampled on Start)
data_in  input  DATA_WIDTH  upstream activation
data_valid  input  1  upstream word available
data_ready  output  1  writer accepts data_in this cycle
buf_ready  input  1  IFMap buffer not full (circular_buffer ready)
din  output  DATA_WIDTH+2  tagged word to buffer
write_en  output  1  buffer write strobe
busy  output  1  transfer in progress
done  output  1  one-cycle pulse after last word written

Behaviour:
- Reset (rst=0, async): state IDLE; counters, hold register and din cleared to 0; data_ready=0, write_en=0, busy=0, done=0.
- Tag format: din[DATA_WIDTH+1]=SOR (first word of every row); din[DATA_WIDTH]=EOS (last word of last row); din[DATA_WIDTH-1:0]=data. A 1x1 transfer carries both flags (2'b11).
- FSM states:
  - IDLE: on Start, latch row_len/row_cnt. If either is 0, go to DONE and write nothing. Otherwise go to STREAM with word_idx=0 and row_idx=0.
  - STREAM: single-entry hold register (hold_valid, hold_word).
    - write_en = hold_valid & buf_ready, combinational; din = hold_word.
    - data_ready = ~hold_valid | buf_ready, i.e. the writer accepts a new word when the hold register is empty or is being written this cycle. Zero-bubble throughput: 1 word/cycle while both sides are ready.
    - On accept (data_valid & data_ready): hold_word <= {SOR, EOS, data_in}, where SOR=(word_idx==0) and EOS=(word_idx==row_len-1 && row_idx==row_cnt-1). Then advance word_idx, wrapping to 0 at row_len-1 and incrementing row_idx on wrap.
    - After the EOS word is accepted, data_ready=0 until the next transfer.
    - When the EOS word is written, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in STREAM and DONE.
- Start while busy is ignored; config changes mid-transfer have no effect.
- Latency: a word accepted in cycle N appears on din with write_en in cycle N+1 if buf_ready=1. din holds stable while buf_ready=0.
- Buffer full: buf_ready=0 stalls the writer; no word is dropped or duplicated. Backpressure reaches upstream only through data_ready.
- Upstream gaps (data_valid=0): hold register drains, and write_en=0 once it is empty.
- Simultaneous accept and write in the same cycle is legal. Hold register stays valid with the new word.
- Reset mid-transfer: immediate return to IDLE with everything cleared. Any partially framed row is abandoned; buffer contents are the buffer's responsibility.
- Counter arithmetic is unsigned LEN_WIDTH. The maximum row_len/row_cnt is 2^LEN_WIDTH-1.

Test Plan:
- Reset then Start with row_len=2, row_cnt=1, data 0xFFDF, 0x0020, always ready -> writes 18'h2FFDF then 18'h10020 on consecutive cycles; done pulses one cycle after the second write.
- row_len=7, row_cnt=1, continuous valid -> 7 writes; only word 0 has SOR, only word 6 has EOS; data_ready drops after word 6 is accepted.
- row_len=3, row_cnt=2 -> SOR on words 0 and 3, EOS only on word 5; 6 writes total.
- buf_ready low for 5 cycles mid-row -> write_en=0 and din stable during the stall, data_ready=0 while hold is full; writes resume with no loss or duplication.
- row_len=0, Start -> no write_en, done one cycle later; a second Start pulse while busy is ignored.
- rst asserted after the 2nd of 4 words -> all outputs 0 immediately; a new Start with row_len=1, row_cnt=1 yields a single word tagged 2'b11.
